// File: rtl/asrv32_mem_responder.sv
// asrv32_mem_responder
//   Memory-side responder for the ASRV32 multicycle core. Serves instruction
//   fetches and load/store requests from one word-addressed RAM. Each request
//   is acknowledged for one cycle after WAIT_CYCLES wait states. When both
//   ports request at once, the data port is served first.
//
// Parameters
//   DEPTH        RAM size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states before each acknowledge (0..15)
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_inst_req / i_inst_addr      fetch request (held until ack) and byte address
//   o_inst / o_inst_ack           fetched word and one-cycle acknowledge
//   i_data_req / i_data_we        load/store request and store select
//   i_data_addr / i_data_size     byte address, size (0 byte, 1 half, 2/3 word)
//   i_data_wdata                  right-aligned store data
//   o_data_rdata / o_data_ack     aligned word read and one-cycle acknowledge
//   o_data_err                    misalignment error, qualified by o_data_ack
//
// Build option
//   ASRV32_MEM_MISALIGN_ERR_EN    when defined, misaligned accesses are acked
//                                 with zero data and no write; data accesses
//                                 also flag o_data_err. Otherwise o_data_err
//                                 is tied 0.
module asrv32_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_addr,
    output logic [31:0] o_inst,
    output logic        o_inst_ack,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [31:0] i_data_addr,
    input  logic [1:0]  i_data_size,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_ack,
    output logic        o_data_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           sel_data_q, sel_data_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;

    logic [31:0]    inst_q, inst_d;
    logic           inst_ack_q, inst_ack_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           data_ack_q, data_ack_d;
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
    logic           err_q, err_d;
`endif

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic [31:0]    wword;
    logic [31:0]    rd_word;
    logic           mis;
    logic           mem_we;

    // Address bits above the RAM window are ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_inst_addr[31:AW+2], i_data_addr[31:AW+2]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_data_d = sel_data_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        inst_d     = '0;
        inst_ack_d = 1'b0;
        rdata_d    = '0;
        data_ack_d = 1'b0;
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
        err_d      = 1'b0;
`endif
        be         = '0;
        wword      = '0;
        mis        = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_data_req) begin
                    sel_data_d = 1'b1;
                    we_d       = i_data_we;
                    size_d     = i_data_size;
                    addr_d     = i_data_addr[AW+1:0];
                    wdata_d    = i_data_wdata;
                    state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                    cnt_d      = CNT_INIT;
                end else if (i_inst_req) begin
                    sel_data_d = 1'b0;
                    we_d       = 1'b0;
                    size_d     = 2'd2;
                    addr_d     = i_inst_addr[AW+1:0];
                    state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                    cnt_d      = CNT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The access itself is performed on the edge entering ACK. The _d
        // view of the captured fields covers both the zero-wait case (capture
        // and access on the same edge) and the waited case.
        idx     = addr_d[AW+1:2];
        rd_word = mem[idx];

        case (size_d)
            2'd0: begin
                be    = 4'b0001 << addr_d[1:0];
                wword = {4{wdata_d[7:0]}};
            end
            2'd1: begin
                be    = addr_d[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_d[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = wdata_d;
            end
        endcase

`ifdef ASRV32_MEM_MISALIGN_ERR_EN
        if (!sel_data_d) begin
            mis = (addr_d[1:0] != 2'b00);
        end else if (size_d == 2'd0) begin
            mis = 1'b0;
        end else if (size_d == 2'd1) begin
            mis = addr_d[0];
        end else begin
            mis = (addr_d[1:0] != 2'b00);
        end
`endif

        if (state_d == S_ACK) begin
            if (sel_data_d) begin
                data_ack_d = 1'b1;
                rdata_d    = mis ? '0 : rd_word;
                mem_we     = we_d && !mis;
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
                err_d      = mis;
`endif
            end else begin
                inst_ack_d = 1'b1;
                inst_d     = mis ? '0 : rd_word;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_data_q <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            inst_q     <= '0;
            inst_ack_q <= 1'b0;
            rdata_q    <= '0;
            data_ack_q <= 1'b0;
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_data_q <= sel_data_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            inst_q     <= inst_d;
            inst_ack_q <= inst_ack_d;
            rdata_q    <= rdata_d;
            data_ack_q <= data_ack_d;
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // RAM is not reset; reset only blocks a pending write.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    assign o_inst       = inst_q;
    assign o_inst_ack   = inst_ack_q;
    assign o_data_rdata = rdata_q;
    assign o_data_ack   = data_ack_q;
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
    assign o_data_err   = err_q;
`else
    assign o_data_err   = 1'b0;
`endif

endmodule

// File: tb/tb_asrv32_mem_responder.sv
// Testbench for asrv32_mem_responder: a byte-array memory model plus a queue
// of expected acknowledges, compared against the DUT every cycle, with
// directed transactions and literal expectations. A second instance with
// WAIT_CYCLES=3 covers reset abandoning a pending store.
module tb_asrv32_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int          WAITC = 1;
    localparam int unsigned MASK  = DEPTH * 4 - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        inst_ack;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        data_ack;
    logic        data_err;

    asrv32_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_inst_req(inst_req), .i_inst_addr(inst_addr),
        .o_inst(inst), .o_inst_ack(inst_ack),
        .i_data_req(data_req), .i_data_we(data_we), .i_data_addr(data_addr),
        .i_data_size(data_size), .i_data_wdata(wdata),
        .o_data_rdata(rdata), .o_data_ack(data_ack), .o_data_err(data_err)
    );

    logic        rst3;
    logic        req3;
    logic        we3;
    logic [31:0] addr3;
    logic [31:0] wdata3;
    logic [31:0] rdata3;
    logic [31:0] inst3;
    logic        ack3;
    logic        iack3;
    logic        err3;

    asrv32_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst3),
        .i_inst_req(1'b0), .i_inst_addr(32'h0),
        .o_inst(inst3), .o_inst_ack(iack3),
        .i_data_req(req3), .i_data_we(we3), .i_data_addr(addr3),
        .i_data_size(2'd2), .i_data_wdata(wdata3),
        .o_data_rdata(rdata3), .o_data_ack(ack3), .o_data_err(err3)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    logic [7:0] mdl_mem [DEPTH*4];

    typedef struct {
        int          cyc;
        bit          is_data;
        bit          rd_care;
        logic [31:0] rd;
        bit          err;
    } exp_t;
    exp_t expq[$];

    function automatic logic [31:0] mdl_word(input logic [31:0] a);
        int unsigned b;
        b = (a & MASK) & ~32'd3;
        return {mdl_mem[b+3], mdl_mem[b+2], mdl_mem[b+1], mdl_mem[b]};
    endfunction

    function automatic bit mdl_mis(input bit is_data, input logic [1:0] size, input logic [31:0] a);
`ifdef ASRV32_MEM_MISALIGN_ERR_EN
        if (!is_data) return a[1:0] != 2'b00;
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return a[0];
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic mdl_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] wd);
        int unsigned b;
        b = a & MASK;
        if (size == 2'd0) begin
            mdl_mem[b] = wd[7:0];
        end else if (size == 2'd1) begin
            b = b & ~32'd1;
            mdl_mem[b]   = wd[7:0];
            mdl_mem[b+1] = wd[15:8];
        end else begin
            b = b & ~32'd3;
            for (int k = 0; k < 4; k++) mdl_mem[b+k] = wd[8*k +: 8];
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : cmp
        exp_t        e;
        logic        x_iack, x_dack, x_err, rd_care;
        logic [31:0] x_inst, x_rd;
        if (cyc >= 1) begin
            x_iack = 1'b0; x_dack = 1'b0; x_err = 1'b0; rd_care = 1'b1;
            x_inst = '0;   x_rd = '0;
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                e = expq.pop_front();
                if (e.is_data) begin
                    x_dack  = 1'b1;
                    x_err   = e.err;
                    x_rd    = e.rd;
                    rd_care = e.rd_care;
                end else begin
                    x_iack = 1'b1;
                    x_inst = e.rd;
                end
            end
            vectors++;
            if ({inst_ack, data_ack, data_err, inst} !== {x_iack, x_dack, x_err, x_inst} ||
                (rd_care && rdata !== x_rd)) begin
                miscompares++;
                $display("FAIL cycle%0d outputs: got iack=%b inst=%h dack=%b rdata=%h err=%b, expected iack=%b inst=%h dack=%b rdata=%h err=%b",
                         cyc, inst_ack, inst, data_ack, rdata, data_err, x_iack, x_inst, x_dack, x_rd, x_err);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic data_txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err,
                            output int lat);
        int   n;
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        data_req = 1'b1; data_we = we; data_size = size; data_addr = addr; wdata = wd;
        n = cyc;
        e.cyc     = n + 1 + WAITC;
        e.is_data = 1'b1;
        e.err     = mdl_mis(1'b1, size, addr);
        e.rd_care = !we || e.err;
        e.rd      = e.err ? 32'h0 : mdl_word(addr);
        if (we && !e.err) mdl_store(size, addr, wd);
        expq.push_back(e);
        rd = '0; err = 1'b0; lat = -1; seen = 1'b0;
        @(posedge clk); #1;
        // Captured values must be used, not the live inputs.
        data_we = ~we; data_size = ~size; data_addr = 32'hFFFF_FFFC; wdata = ~wd;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (data_ack) begin
                seen = 1'b1; rd = rdata; err = data_err; lat = cyc - n;
            end
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL data_ack_timeout: got no ack, required ack at cycle %0d", e.cyc);
            expq.delete();
        end
        @(posedge clk); #1;
        data_req = 1'b0;
    endtask

    task automatic inst_txn(input logic [31:0] addr, output logic [31:0] rd, output int lat);
        int   n;
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = addr;
        n = cyc;
        e.cyc = n + 1 + WAITC; e.is_data = 1'b0; e.rd_care = 1'b1; e.err = 1'b0;
        e.rd  = mdl_mis(1'b0, 2'd2, addr) ? 32'h0 : mdl_word(addr);
        expq.push_back(e);
        rd = '0; lat = -1; seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (inst_ack) begin
                seen = 1'b1; rd = inst; lat = cyc - n;
            end
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL inst_ack_timeout: got no ack, required ack at cycle %0d", e.cyc);
            expq.delete();
        end
        @(posedge clk); #1;
        inst_req = 1'b0;
    endtask

    // Data store and fetch raised together; the fetch stays pending.
    task automatic both_txn(input logic [31:0] daddr, input logic [31:0] wd, input logic [31:0] iaddr,
                            output logic [31:0] ird, output int dlat, output int gap);
        int   n, dc, ic;
        exp_t e;
        bit   dseen, iseen;
        @(posedge clk); #1;
        data_req = 1'b1; data_we = 1'b1; data_size = 2'd2; data_addr = daddr; wdata = wd;
        inst_req = 1'b1; inst_addr = iaddr;
        n = cyc;
        e.cyc = n + 1 + WAITC; e.is_data = 1'b1; e.rd_care = 1'b0; e.err = 1'b0; e.rd = '0;
        expq.push_back(e);
        mdl_store(2'd2, daddr, wd);
        e.cyc = n + 3 + 2 * WAITC; e.is_data = 1'b0; e.rd_care = 1'b1; e.rd = mdl_word(iaddr);
        expq.push_back(e);
        dseen = 1'b0; iseen = 1'b0; dc = -100; ic = -1; ird = '0;
        for (int k = 0; k < 60 && !iseen; k++) begin
            @(negedge clk);
            if (data_ack && !dseen) begin
                dseen = 1'b1; dc = cyc;
                @(posedge clk); #1;
                data_req = 1'b0;
            end else if (inst_ack) begin
                iseen = 1'b1; ic = cyc; ird = inst;
            end
        end
        if (!iseen || !dseen) begin
            vectors++; miscompares++;
            $display("FAIL both_timeout: got dack=%b iack=%b, required both", dseen, iseen);
            expq.delete();
        end
        @(posedge clk); #1;
        data_req = 1'b0; inst_req = 1'b0;
        dlat = dc - n; gap = ic - dc;
    endtask

    task automatic d3_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        int n;
        bit seen;
        @(posedge clk); #1;
        req3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wd;
        n = cyc; seen = 1'b0; lat = -1; rd = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (ack3) begin
                seen = 1'b1; rd = rdata3; lat = cyc - n;
            end
        end
        @(posedge clk); #1;
        req3 = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        err;
        int          lat, gap, acks;

        rst = 1'b1; rst3 = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_size = '0; wdata = '0;
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", inst, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_flags", {29'h0, inst_ack, data_ack, data_err}, 32'h0);
        rst = 1'b0; rst3 = 1'b0;

        // Fetch: ack 2 cycles after request, then low.
        data_txn(1'b1, 2'd2, 32'h0000_0010, 32'h0051_0093, rd, err, lat);
        inst_txn(32'h0000_0010, rd, lat);
        check("fetch_word", rd, 32'h0051_0093);
        check("fetch_latency", lat, 32'd2);
        check("fetch_ack_drop", {31'h0, inst_ack}, 32'h0);

        // Store lanes.
        data_txn(1'b1, 2'd2, 32'h40, 32'hDEAD_BEEF, rd, err, lat);
        check("store_latency", lat, 32'd2);
        data_txn(1'b1, 2'd0, 32'h41, 32'hCAFE_0011, rd, err, lat);
        data_txn(1'b0, 2'd2, 32'h40, 32'h0, rd, err, lat);
        check("byte_store_load", rd, 32'hDEAD_11EF);
        data_txn(1'b1, 2'd1, 32'h42, 32'h5555_AAAA, rd, err, lat);
        data_txn(1'b0, 2'd2, 32'h40, 32'h0, rd, err, lat);
        check("half_store_load", rd, 32'hAAAA_11EF);

        for (int i = 0; i < 4; i++)
            data_txn(1'b1, 2'd0, 32'h100 + i, 32'hFFFF_FFA0 + i, rd, err, lat);
        data_txn(1'b0, 2'd2, 32'h101, 32'h0, rd, err, lat);
        check("byte_lanes", rd, 32'hA3A2_A1A0);
        data_txn(1'b1, 2'd2, 32'h104, 32'h0, rd, err, lat);
        data_txn(1'b1, 2'd1, 32'h104, 32'h9999_1234, rd, err, lat);
        data_txn(1'b0, 2'd0, 32'h104, 32'h0, rd, err, lat);
        check("half_low_lanes", rd, 32'h0000_1234);

        // Simultaneous: data first, fetch acks 3 cycles later and sees the store.
        data_txn(1'b1, 2'd2, 32'h200, 32'h0, rd, err, lat);
        both_txn(32'h200, 32'h0BAD_F00D, 32'h200, rd, lat, gap);
        check("both_data_latency", lat, 32'd2);
        check("both_fetch_gap", gap, 32'd3);
        check("both_fetch_word", rd, 32'h0BAD_F00D);

        // Address wrap modulo DEPTH*4.
        data_txn(1'b1, 2'd2, 32'h0000_1000, 32'h1234_5678, rd, err, lat);
        data_txn(1'b0, 2'd2, 32'h0000_0000, 32'h0, rd, err, lat);
        check("wrap_load", rd, 32'h1234_5678);

`ifdef ASRV32_MEM_MISALIGN_ERR_EN
        data_txn(1'b1, 2'd2, 32'h42, 32'h5555_5555, rd, err, lat);
        check("mis_word_err", {31'h0, err}, 32'h1);
        data_txn(1'b0, 2'd2, 32'h40, 32'h0, rd, err, lat);
        check("mis_mem_unchanged", rd, 32'hAAAA_11EF);
        data_txn(1'b0, 2'd1, 32'h42, 32'h0, rd, err, lat);
        check("half_aligned_err", {31'h0, err}, 32'h0);
        inst_txn(32'h12, rd, lat);
        check("mis_fetch_zero", rd, 32'h0);
`endif

        // Reset during WAIT abandons the store (WAIT_CYCLES=3 instance).
        d3_txn(1'b1, 32'h80, 32'h0, rd, lat);
        check("w3_latency", lat, 32'd4);
        @(posedge clk); #1;
        req3 = 1'b1; we3 = 1'b1; addr3 = 32'h80; wdata3 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        rst3 = 1'b1; req3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b0;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack3 || iack3) acks++;
        end
        check("w3_rst_no_ack", acks, 32'd0);
        d3_txn(1'b0, 32'h80, 32'h0, rd, lat);
        check("w3_rst_no_write", rd, 32'h0);
        check("w3_load_latency", lat, 32'd4);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", expq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
